// File: rtl/diff_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// diff_pkg
// Shared definitions for the bit-difference sequencer.
//   - state_e      : sequencer state encoding (IDLE / SCAN / DONE)
//   - DEF_WIDTH    : default operand width
//   - DEF_TAGW     : default requester tag width
//   - DEF_IDXW     : default result width, wide enough to encode DEF_WIDTH
// -----------------------------------------------------------------------------
package diff_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_TAGW  = 5;
  localparam int DEF_IDXW  = $clog2(DEF_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : diff_pkg

// File: rtl/diff_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// diff_seq_ctrl_if
// Request/response channel between the control path (master) and the
// bit-difference unit (slave).
//   Request : req_valid, req_ready, req_a, req_b, req_tag
//   Response: rsp_valid, rsp_ready, rsp_idx, rsp_equal, rsp_tag
// -----------------------------------------------------------------------------
interface diff_seq_ctrl_if
  import diff_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAGW  = DEF_TAGW,
  parameter int IDXW  = $clog2(WIDTH) + 1
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAGW-1:0]  req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDXW-1:0]  rsp_idx;
  logic             rsp_equal;
  logic [TAGW-1:0]  rsp_tag;

  modport master (
    output req_valid, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_idx, rsp_equal, rsp_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_idx, rsp_equal, rsp_tag
  );

endinterface : diff_seq_ctrl_if

// File: rtl/diff_seq_ctrl.sv
// -----------------------------------------------------------------------------
// diff_seq_ctrl
// Shared functional unit that returns the index of the least-significant bit
// where two operands differ. The XOR of the operands is scanned one bit per
// cycle with early termination; A==B short-circuits straight to the result.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   flush_i  in   synchronous abort; wins over every handshake
//   busy_o   out  sequencer is not IDLE
//   bus      slave modport of diff_seq_ctrl_if (request / response channel)
// -----------------------------------------------------------------------------
module diff_seq_ctrl
  import diff_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAGW  = DEF_TAGW,
  parameter int IDXW  = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  output logic                 busy_o,
  diff_seq_ctrl_if.slave       bus
);

  localparam int CNTW = $clog2(WIDTH);

  // Result encoding used when the operands are identical.
  localparam logic [IDXW-1:0] IDX_EQUAL = IDXW'(WIDTH);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  x_q,     x_d;
  logic [CNTW-1:0]   cnt_q,   cnt_d;
  logic [TAGW-1:0]   tag_q,   tag_d;
  logic [IDXW-1:0]   idx_q,   idx_d;
  logic              equal_q, equal_d;

  logic [WIDTH-1:0]  diff_w;

  assign diff_w = bus.req_a ^ bus.req_b;

  // State and datapath registers. Every register has a defined reset value so
  // the response outputs read zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
      equal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      equal_q <= equal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    equal_d = equal_q;

    if (flush_i) begin
      // Abort drops any pending result; the stale idx/tag are never presented
      // because rsp_valid follows the state.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            x_d   = diff_w;
            cnt_d = '0;
            tag_d = bus.req_tag;
            if (diff_w == '0) begin
              idx_d   = IDX_EQUAL;
              equal_d = 1'b1;
              state_d = DONE;
            end else begin
              state_d = SCAN;
            end
          end
        end

        SCAN: begin
          // x is nonzero on entry, so a set bit reaches x[0] before cnt can
          // pass WIDTH-1 and the counter never wraps.
          if (x_q[0]) begin
            idx_d   = IDXW'(cnt_q);
            equal_d = 1'b0;
            state_d = DONE;
          end else begin
            x_d   = x_q >> 1;
            cnt_d = cnt_q + 1'b1;
          end
        end

        DONE: begin
          // Return to IDLE on the handshake; the next request is only seen
          // a cycle later, so there is no response-to-request turnaround.
          if (bus.rsp_ready) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // All outputs decode registered state only.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_idx   = idx_q;
  assign bus.rsp_equal = equal_q;
  assign bus.rsp_tag   = tag_q;
  assign busy_o        = (state_q != IDLE);

endmodule : diff_seq_ctrl

// File: tb/tb_diff_seq_ctrl.sv
module tb_diff_seq_ctrl;

  logic clk;
  logic rst;
  logic flush;
  logic busy;

  int total;
  int bad;

  diff_seq_ctrl_if #(.WIDTH(32), .TAGW(5)) bus ();

  diff_seq_ctrl #(.WIDTH(32), .TAGW(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .busy_o  (busy),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one request at a negedge, let it be accepted, then wait for
  // rsp_valid. lat counts the accepting cycle as 1. Ends at a negedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output int lat,
                       output bit busy_all);
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat      = 1;
    busy_all = 1'b1;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 60) begin
      if (!busy) busy_all = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!busy) busy_all = 1'b0;
  endtask

  // Complete the response handshake; ends at the following negedge.
  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (bus.rsp_idx !== 6'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", bus.rsp_idx); end
    total++; if (bus.rsp_equal !== 1'b0) begin bad++; $display("FAIL reset_equal got=%b exp=0", bus.rsp_equal); end
    total++; if (bus.rsp_tag !== 5'd0) begin bad++; $display("FAIL reset_tag got=%0d exp=0", bus.rsp_tag); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_bit();
    int lat;
    bit ba;
    issue(32'h0000_0000, 32'h0000_0001, 5'd7, lat, ba);
    total++; if (lat !== 2) begin bad++; $display("FAIL bit0_latency got=%0d exp=2", lat); end
    total++; if (bus.rsp_idx !== 6'd0) begin bad++; $display("FAIL bit0_idx got=%0d exp=0", bus.rsp_idx); end
    total++; if (bus.rsp_equal !== 1'b0) begin bad++; $display("FAIL bit0_equal got=%b exp=0", bus.rsp_equal); end
    total++; if (bus.rsp_tag !== 5'd7) begin bad++; $display("FAIL bit0_tag got=%0d exp=7", bus.rsp_tag); end
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL bit0_req_ready_in_done got=%b exp=0", bus.req_ready); end
    take_rsp();
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL bit0_req_ready_after got=%b exp=1", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bit0_rsp_valid_after got=%b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_msb();
    int lat;
    bit ba;
    issue(32'hFFFF_FFFF, 32'h7FFF_FFFF, 5'd3, lat, ba);
    total++; if (lat !== 33) begin bad++; $display("FAIL msb_latency got=%0d exp=33", lat); end
    total++; if (bus.rsp_idx !== 6'd31) begin bad++; $display("FAIL msb_idx got=%0d exp=31", bus.rsp_idx); end
    total++; if (ba !== 1'b1) begin bad++; $display("FAIL msb_busy_throughout got=%b exp=1", ba); end
    total++; if (bus.rsp_tag !== 5'd3) begin bad++; $display("FAIL msb_tag got=%0d exp=3", bus.rsp_tag); end
    take_rsp();
  endtask

  task automatic test_equal();
    int lat;
    bit ba;
    issue(32'h1234_5678, 32'h1234_5678, 5'd21, lat, ba);
    total++; if (lat !== 1) begin bad++; $display("FAIL eq_latency got=%0d exp=1", lat); end
    total++; if (bus.rsp_idx !== 6'd32) begin bad++; $display("FAIL eq_idx got=%0d exp=32", bus.rsp_idx); end
    total++; if (bus.rsp_equal !== 1'b1) begin bad++; $display("FAIL eq_equal got=%b exp=1", bus.rsp_equal); end
    total++; if (bus.rsp_tag !== 5'd21) begin bad++; $display("FAIL eq_tag got=%0d exp=21", bus.rsp_tag); end
    take_rsp();
  endtask

  task automatic test_back_to_back_stall();
    int lat;
    bit ba;
    issue(32'h0000_00F0, 32'h0000_00E0, 5'd9, lat, ba);
    total++; if (lat !== 6) begin bad++; $display("FAIL stall_latency got=%0d exp=6", lat); end
    // A second request waits on the channel while the response is stalled.
    bus.req_a     = 32'h0;
    bus.req_b     = 32'h1;
    bus.req_tag   = 5'd30;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, bus.rsp_valid); end
      total++; if (bus.rsp_idx !== 6'd4) begin bad++; $display("FAIL stall_idx[%0d] got=%0d exp=4", i, bus.rsp_idx); end
      total++; if (bus.rsp_tag !== 5'd9) begin bad++; $display("FAIL stall_tag[%0d] got=%0d exp=9", i, bus.rsp_tag); end
      total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL stall_req_ready[%0d] got=%b exp=0", i, bus.req_ready); end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL stall_req_ready_after got=%b exp=1", bus.req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_second_not_accepted busy=%b exp=0", busy); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL stall_rsp_valid_after got=%b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_flush();
    int lat;
    bit ba;
    bit seen;
    bus.req_a     = 32'h8000_0000;
    bus.req_b     = 32'h0;
    bus.req_tag   = 5'd11;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL flush_req_ready got=%b exp=1", bus.req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_response seen=%b exp=0", seen); end
    // Request coincident with flush must be refused.
    flush         = 1'b1;
    bus.req_a     = 32'h1;
    bus.req_b     = 32'h0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_blocks_req busy=%b exp=0", busy); end
    issue(32'h0000_0002, 32'h0000_0000, 5'd12, lat, ba);
    total++; if (lat !== 3) begin bad++; $display("FAIL post_flush_latency got=%0d exp=3", lat); end
    total++; if (bus.rsp_idx !== 6'd1) begin bad++; $display("FAIL post_flush_idx got=%0d exp=1", bus.rsp_idx); end
    total++; if (bus.rsp_tag !== 5'd12) begin bad++; $display("FAIL post_flush_tag got=%0d exp=12", bus.rsp_tag); end
    // Flush beats a coincident response handshake; result is dropped.
    flush         = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_in_done_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL flush_in_done_req_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_async_reset();
    int lat;
    bit ba;
    bus.req_a     = 32'h0000_0100;
    bus.req_b     = 32'h0;
    bus.req_tag   = 5'd17;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL arst_req_ready got=%b exp=1", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL arst_rsp_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", busy); end
    total++; if (bus.rsp_idx !== 6'd0) begin bad++; $display("FAIL arst_idx got=%0d exp=0", bus.rsp_idx); end
    total++; if (bus.rsp_equal !== 1'b0) begin bad++; $display("FAIL arst_equal got=%b exp=0", bus.rsp_equal); end
    total++; if (bus.rsp_tag !== 5'd0) begin bad++; $display("FAIL arst_tag got=%0d exp=0", bus.rsp_tag); end
    #1 rst = 1'b0;
    @(negedge clk);
    issue(32'h0000_0100, 32'h0000_0000, 5'd17, lat, ba);
    total++; if (lat !== 10) begin bad++; $display("FAIL arst_after_latency got=%0d exp=10", lat); end
    total++; if (bus.rsp_idx !== 6'd8) begin bad++; $display("FAIL arst_after_idx got=%0d exp=8", bus.rsp_idx); end
    total++; if (bus.rsp_tag !== 5'd17) begin bad++; $display("FAIL arst_after_tag got=%0d exp=17", bus.rsp_tag); end
    take_rsp();
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b0;

    test_reset();
    test_first_bit();
    test_msb();
    test_equal();
    test_back_to_back_stall();
    test_flush();
    test_async_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_diff_seq_ctrl
